// File: rtl/fetch_pkg.sv
// Shared defaults and entry layout for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEFAULT   = 8;
    localparam int unsigned INSTR_W_DEFAULT  = 8;
    localparam int unsigned DEPTH_DEFAULT    = 2;
    localparam int unsigned RESET_PC_DEFAULT = 0;

    // Entry layout at default widths; the FIFO stores the same {instr, pc} packing.
    typedef struct packed {
        logic [INSTR_W_DEFAULT-1:0] instr;
        logic [ADDR_W_DEFAULT-1:0]  pc;
    } fetch_entry_t;

    function automatic int unsigned entry_width(int unsigned addr_w, int unsigned instr_w);
        return addr_w + instr_w;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head entry is read combinationally from storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i) count_d = count_q + CNT_W'(1);
            if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, reads IMEM and queues {instr, pc} for decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned        INSTR_W  = INSTR_W_DEFAULT,
    parameter int unsigned        DEPTH    = DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    input  logic                       halt,
    input  logic                       redirect_en,
    input  logic [ADDR_W-1:0]          redirect_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc_plus_one,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic [INSTR_W-1:0]         display
);

    localparam int unsigned ENTRY_W = entry_width(ADDR_W, INSTR_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               push, pop, full;
    logic [ENTRY_W-1:0] head;

    // Occupancy is sampled at cycle start: a same-cycle pop does not make room for a push.
    assign full = (buf_count == CNT_W'(DEPTH));

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        fetch_pc_d = fetch_pc_q;
        if (redirect_en) begin
            fetch_pc_d = redirect_target;
        end else begin
            push = !halt && !full;
            pop  = out_valid && out_ready;
            if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_en),
        .wdata_i ({imem_data, fetch_pc_q}),
        .rdata_o (head),
        .count_o (buf_count)
    );

    assign imem_addr       = fetch_pc_q;
    assign out_valid       = (buf_count != '0);
    assign out_instr       = head[ENTRY_W-1 -: INSTR_W];
    assign out_pc          = head[ADDR_W-1:0];
    assign out_pc_plus_one = out_pc + ADDR_W'(1);
    assign display         = out_valid ? out_instr : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Drives three fetch_queue configurations with shared stimulus against a queue-based model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halt = 1'b0;
    logic        redir = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] tgt = '0;

    always #5 clk = ~clk;

    // a: 8/8/2 RESET_PC 0, b: 8/8/2 RESET_PC FE, c: 12/16/4 RESET_PC 0
    logic [7:0]  addr_a, data_a, instr_a, pc_a, ppo_a, disp_a;
    logic [7:0]  addr_b, data_b, instr_b, pc_b, ppo_b, disp_b;
    logic [11:0] addr_c, pc_c, ppo_c;
    logic [15:0] data_c, instr_c, disp_c;
    logic        valid_a, valid_b, valid_c;
    logic [1:0]  cnt_a, cnt_b;
    logic [2:0]  cnt_c;

    assign data_a = addr_a + 8'h10;
    assign data_b = addr_b + 8'h10;
    assign data_c = 16'(addr_c) * 16'd3 + 16'h1000;

    fetch_queue #(.ADDR_W(8), .INSTR_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut_a (
        .clk(clk), .reset(reset), .imem_addr(addr_a), .imem_data(data_a), .halt(halt),
        .redirect_en(redir), .redirect_target(tgt[7:0]), .out_valid(valid_a),
        .out_ready(ready), .out_instr(instr_a), .out_pc(pc_a), .out_pc_plus_one(ppo_a),
        .buf_count(cnt_a), .display(disp_a)
    );
    fetch_queue #(.ADDR_W(8), .INSTR_W(8), .DEPTH(2), .RESET_PC(8'hFE)) dut_b (
        .clk(clk), .reset(reset), .imem_addr(addr_b), .imem_data(data_b), .halt(halt),
        .redirect_en(redir), .redirect_target(tgt[7:0]), .out_valid(valid_b),
        .out_ready(ready), .out_instr(instr_b), .out_pc(pc_b), .out_pc_plus_one(ppo_b),
        .buf_count(cnt_b), .display(disp_b)
    );
    fetch_queue #(.ADDR_W(12), .INSTR_W(16), .DEPTH(4), .RESET_PC(12'h000)) dut_c (
        .clk(clk), .reset(reset), .imem_addr(addr_c), .imem_data(data_c), .halt(halt),
        .redirect_en(redir), .redirect_target(tgt[11:0]), .out_valid(valid_c),
        .out_ready(ready), .out_instr(instr_c), .out_pc(pc_c), .out_pc_plus_one(ppo_c),
        .buf_count(cnt_c), .display(disp_c)
    );

    logic [31:0] o_addr [3], o_valid [3], o_instr [3], o_pc [3], o_ppo [3], o_cnt [3], o_disp [3];
    assign o_addr[0]  = 32'(addr_a);  assign o_addr[1]  = 32'(addr_b);  assign o_addr[2]  = 32'(addr_c);
    assign o_valid[0] = 32'(valid_a); assign o_valid[1] = 32'(valid_b); assign o_valid[2] = 32'(valid_c);
    assign o_instr[0] = 32'(instr_a); assign o_instr[1] = 32'(instr_b); assign o_instr[2] = 32'(instr_c);
    assign o_pc[0]    = 32'(pc_a);    assign o_pc[1]    = 32'(pc_b);    assign o_pc[2]    = 32'(pc_c);
    assign o_ppo[0]   = 32'(ppo_a);   assign o_ppo[1]   = 32'(ppo_b);   assign o_ppo[2]   = 32'(ppo_c);
    assign o_cnt[0]   = 32'(cnt_a);   assign o_cnt[1]   = 32'(cnt_b);   assign o_cnt[2]   = 32'(cnt_c);
    assign o_disp[0]  = 32'(disp_a);  assign o_disp[1]  = 32'(disp_b);  assign o_disp[2]  = 32'(disp_c);

    // Reference model: per-configuration list of queued {pc, instr} plus fetch PC.
    int unsigned depth_m [3] = '{2, 2, 4};
    logic [31:0] amask   [3] = '{32'hFF, 32'hFF, 32'hFFF};
    logic [31:0] rpc     [3] = '{32'h00, 32'hFE, 32'h000};
    logic [31:0] m_pc    [3];
    logic [31:0] q_pc    [3][4];
    logic [31:0] q_in    [3][4];
    int unsigned q_n     [3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] imem_val(int k, logic [31:0] a);
        if (k == 2) return (a * 32'd3 + 32'h1000) & 32'hFFFF;
        return (a + 32'h10) & 32'hFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pc[k] = rpc[k];
            q_n[k]  = 0;
        end
    endtask

    task automatic model_step(int k, bit h, bit r, logic [31:0] t, bit rdy);
        bit          do_pop;
        bit          do_push;
        logic [31:0] e_pc;
        logic [31:0] e_in;
        if (r) begin
            q_n[k]  = 0;
            m_pc[k] = t & amask[k];
        end else begin
            do_pop  = (q_n[k] > 0) && rdy;
            do_push = !h && (q_n[k] < depth_m[k]);
            e_pc    = m_pc[k];
            e_in    = imem_val(k, m_pc[k]);
            if (do_pop) begin
                for (int i = 0; i < 3; i++) begin
                    q_pc[k][i] = q_pc[k][i+1];
                    q_in[k][i] = q_in[k][i+1];
                end
                q_n[k]--;
            end
            if (do_push) begin
                q_pc[k][q_n[k]] = e_pc;
                q_in[k][q_n[k]] = e_in;
                q_n[k]++;
                m_pc[k] = (m_pc[k] + 1) & amask[k];
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string ph);
        logic [31:0] ev;
        for (int k = 0; k < 3; k++) begin
            ev = (q_n[k] > 0) ? 32'd1 : 32'd0;
            chk($sformatf("%s/dut%0d/imem_addr", ph, k), o_addr[k], m_pc[k]);
            chk($sformatf("%s/dut%0d/out_valid", ph, k), o_valid[k], ev);
            chk($sformatf("%s/dut%0d/buf_count", ph, k), o_cnt[k], 32'(q_n[k]));
            chk($sformatf("%s/dut%0d/display", ph, k), o_disp[k],
                (q_n[k] > 0) ? q_in[k][0] : 32'd0);
            if (q_n[k] > 0) begin
                chk($sformatf("%s/dut%0d/out_pc", ph, k), o_pc[k], q_pc[k][0]);
                chk($sformatf("%s/dut%0d/out_instr", ph, k), o_instr[k], q_in[k][0]);
                chk($sformatf("%s/dut%0d/pc_plus_one", ph, k), o_ppo[k],
                    (q_pc[k][0] + 1) & amask[k]);
            end
        end
    endtask

    // Called just after a rising edge: apply inputs, check state at the falling edge,
    // advance the model across the next rising edge.
    task automatic step(string ph, bit h, bit r, logic [31:0] t, bit rdy);
        halt  = h;
        redir = r;
        tgt   = t;
        ready = rdy;
        @(negedge clk);
        check_all(ph);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, h, r, t, rdy);
        #1;
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1 check_all("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        repeat (8) step("stream", 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (5) step("stall", 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) step("release", 1'b0, 1'b0, 32'h0, 1'b1);

        repeat (3) step("fill", 1'b0, 1'b0, 32'h0, 1'b0);
        step("redirect", 1'b0, 1'b1, 32'h40, 1'b0);
        repeat (4) step("post_redir", 1'b0, 1'b0, 32'h0, 1'b1);

        repeat (3) step("prehalt", 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (5) step("halt", 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) step("resume", 1'b0, 1'b0, 32'h0, 1'b1);
        step("redir_halt", 1'b1, 1'b1, 32'hFFE, 1'b1);
        repeat (3) step("halt2", 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) step("resume2", 1'b0, 1'b0, 32'h0, 1'b1);

        repeat (2) step("prereset", 1'b0, 1'b0, 32'h0, 1'b0);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("async_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        repeat (6) step("post_reset", 1'b0, 1'b0, 32'h0, 1'b1);

        repeat (300) begin
            step("random", ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 $urandom, ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
